gcd_seg_display: RTL and testbench
==================================

GCD_SEG_DISPLAY -- requirements
Module: gcd_seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port seg_data_16, input, 16 bits: four BCD nibbles; [15:12] is the leftmost digit.
REQ-005 SHALL have port gcd_result, input, 32 bits: unsigned binary result.
REQ-006 SHALL have port cpu_state, input, 1 bit: 0 selects input mode, 1 selects result mode.
REQ-007 SHALL have port seg_an, output, 4 bits: digit enables, active-low; bit k drives digit k, and digit 3 is leftmost.
REQ-008 SHALL have port seg_seg, output, 8 bits: segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-009 Scan counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-010 seg_an and seg_seg SHALL be registered, reflecting the digit index and data with exactly 1 cycle latency; exactly one seg_an bit SHALL be low outside reset.
REQ-011 Encoding SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex), dash=BF, blank=FF.
REQ-012 Input mode SHALL display seg_data_16 nibbles directly, with no blanking.
REQ-013 Input mode SHALL render nibble values 10-15 as blank.
REQ-014 Input mode SHALL light dp (bit 7 = 0) on digit 2 only, as the A/B separator.
REQ-015 Result mode SHALL display a committed 4-digit BCD register.
REQ-016 Result mode SHALL blank leading zeros in digits 3..1; digit 0 is always shown.
REQ-017 Result mode SHALL keep dp off on every digit.
REQ-018 Converter FSM SHALL have states IDLE, LOAD, SHIFT, COMMIT.
REQ-019 In IDLE, when gcd_result != latched value, the FSM SHALL go to LOAD, capturing gcd_result into the latched value.
REQ-020 LOAD SHALL clear the BCD shift register and load binary bits [13:0], then go to SHIFT.
REQ-021 SHIFT SHALL run 14 shift-add-3 (double-dabble) iterations, one per cycle, then go to COMMIT.
REQ-022 COMMIT SHALL write the BCD display register, then return to IDLE; total latency from IDLE detection to display register update SHALL be 16 cycles.
REQ-023 If the latched value is > 9999, COMMIT SHALL set an overflow flag instead, and the display SHALL show four dashes.
REQ-024 Changes on gcd_result during LOAD/SHIFT/COMMIT SHALL be ignored; the next IDLE cycle re-compares and restarts conversion.
REQ-025 The display register SHALL change only at COMMIT, so there is no partial-value tearing.
REQ-026 A cpu_state change SHALL take effect at the next output register update; the scan position SHALL be unaffected.
REQ-027 The converter SHALL run regardless of cpu_state.

Reset
REQ-028 While rst_n is low, seg_an SHALL be 4'hF and seg_seg SHALL be 8'hFF.
REQ-029 While rst_n is low, scan counter and digit index SHALL be 0.
REQ-030 While rst_n is low, FSM SHALL be IDLE, latched value 0, BCD display register 0, and overflow flag 0.
REQ-031 Reset assertion mid-conversion SHALL abort the conversion immediately; there SHALL be no commit.
REQ-032 The first clock after rst_n deasserts SHALL drive digit 0.

Structure
REQ-033 Package seg_pkg SHALL hold the segment encoding constants (digits, dash, blank), the FSM state type, and DIGITS=4.
REQ-034 The iterative double-dabble SHALL be a sub-module, bin2bcd_seq, with a start/done handshake, 14-bit input, and 16-bit BCD output.

Verification
REQ-035 Reset test: hold rst_n low with random inputs -> seg_an=F, seg_seg=FF; release rst_n -> seg_an=E on the next cycle.
REQ-036 Input-mode scan test: REFRESH_DIV=4, cpu_state=0, seg_data_16=16'h1234 -> (E,99), (D,B0), (B,24), (7,F9), 4 cycles each, repeating.
REQ-037 Result test: cpu_state=1, gcd_result=37 -> display update exactly 16 cycles later; digits 3..0 = FF, FF, B0, F8.
REQ-038 Bound test: gcd_result=9999 -> 90, 90, 90, 90; gcd_result=10000 -> BF on all digits.
REQ-039 Mid-conversion change: gcd_result 12->18 at SHIFT cycle 5 -> commit shows 12, then auto-reconvert; 18 is committed 16 cycles after returning to IDLE.
REQ-040 Abort test: assert rst_n low during SHIFT -> display register stays 0 and nothing is committed; after release with gcd_result=6, 6 is shown 16 cycles after IDLE detection.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the GCD seven-segment display.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int BCD_W  = 16;

  localparam logic [31:0] MAX_SHOWN = 32'd9999;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } cvt_state_e;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/gcd_seg_display_if.sv
// Start/done handshake between the display controller and the
// iterative binary-to-BCD converter.
interface gcd_seg_display_if;
  import seg_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin;
  logic             done;
  logic [BCD_W-1:0] bcd;

  modport master (output start, bin, input done, bcd);
  modport slave  (input start, bin, output done, bcd);

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-add-3 per cycle, 14 cycles.
// done is high during the final iteration; bcd is valid the cycle after.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  gcd_seg_display_if.slave  cv
);

  localparam int SW = BCD_W + BIN_W;
  localparam logic [3:0] LAST = 4'(BIN_W - 1);

  logic [SW-1:0]    sh_q, sh_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [BCD_W-1:0] adj;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    adj = '0;
    for (int i = 0; i < BCD_W / 4; i++) begin
      adj[4*i +: 4] = add3(sh_q[BIN_W + 4*i +: 4]);
    end
  end

  always_comb begin
    sh_d   = sh_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (cv.start) begin
      sh_d   = {{BCD_W{1'b0}}, cv.bin};
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d  = {adj, sh_q[BIN_W-1:0]} << 1;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign cv.done = busy_q && (cnt_q == LAST);
  assign cv.bcd  = sh_q[BIN_W +: BCD_W];

endmodule

// File: rtl/gcd_seg_display.sv
// Four-digit multiplexed display: raw BCD input mode or a converted
// GCD result mode with leading-zero blanking and overflow dashes.
module gcd_seg_display
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seg_data_16,
  input  logic [31:0] gcd_result,
  input  logic        cpu_state,
  output logic [3:0]  seg_an,
  output logic [7:0]  seg_seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        dig_q, dig_d;
  cvt_state_e        state_q, state_d;
  logic [31:0]       lat_q, lat_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [7:0]        seg_q, seg_d;
  logic [3:0]        in_nib, res_nib;
  logic              lead_blank;

  gcd_seg_display_if cv ();

  bin2bcd_seq u_b2b (
    .clk   (clk),
    .rst_n (rst_n),
    .cv    (cv.slave)
  );

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = dig_q + 2'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    disp_d   = disp_q;
    ovf_d    = ovf_q;
    cv.start = 1'b0;
    cv.bin   = lat_q[BIN_W-1:0];
    unique case (state_q)
      IDLE: begin
        if (gcd_result != lat_q) begin
          lat_d   = gcd_result;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cv.start = 1'b1;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (cv.done) state_d = COMMIT;
      end
      COMMIT: begin
        if (lat_q > MAX_SHOWN) begin
          ovf_d = 1'b1;
        end else begin
          disp_d = cv.bcd;
          ovf_d  = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_nib  = seg_data_16[{dig_q, 2'b00} +: 4];
    res_nib = disp_q[{dig_q, 2'b00} +: 4];
    unique case (dig_q)
      2'd3:    lead_blank = (disp_q[15:12] == 4'd0);
      2'd2:    lead_blank = (disp_q[15:8] == 8'd0);
      2'd1:    lead_blank = (disp_q[15:4] == 12'd0);
      default: lead_blank = 1'b0;
    endcase
  end

  always_comb begin
    an_d = ~(DIGITS'(1) << dig_q);
    if (!cpu_state) begin
      seg_d = seg_enc(in_nib);
      if (dig_q == 2'd2) seg_d[7] = 1'b0;
    end else if (ovf_q) begin
      seg_d = SEG_DASH;
    end else if (lead_blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = seg_enc(res_nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dig_q   <= '0;
      state_q <= IDLE;
      lat_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      an_q    <= '1;
      seg_q   <= '1;
    end else begin
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      state_q <= state_d;
      lat_q   <= lat_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_an  = an_q;
  assign seg_seg = seg_q;

endmodule

// File: tb/tb_gcd_seg_display.sv
// Bench for gcd_seg_display: arithmetic reference model checked every
// cycle, plus directed captures against hand-computed digit codes.
module tb_gcd_seg_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] seg_data;
  logic [31:0] gcd;
  logic        cpu_state;
  logic [3:0]  seg_an;
  logic [7:0]  seg_seg;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  gcd_seg_display #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_data_16 (seg_data),
    .gcd_result  (gcd),
    .cpu_state   (cpu_state),
    .seg_an      (seg_an),
    .seg_seg     (seg_seg)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] model_seg(input int k, input bit mode,
                                           input logic [15:0] data,
                                           input int shown, input bit ovf);
    logic [7:0] s;
    int nib;
    int p;
    if (!mode) begin
      nib = int'((data >> (4 * k)) & 16'hF);
      s = (nib > 9) ? 8'hFF : enc(nib);
      if (k == 2) s[7] = 1'b0;
    end else if (ovf) begin
      s = 8'hBF;
    end else begin
      p = 1;
      for (int j = 0; j < k; j++) p = p * 10;
      if (k > 0 && shown < p) s = 8'hFF;
      else s = enc((shown / p) % 10);
    end
    return s;
  endfunction

  // Reference model: scan position, a 16-edge conversion delay, and
  // the committed integer value.
  int          m_cnt = 0, m_dig = 0, m_cd = 0, m_shown = 0;
  logic [31:0] m_lat = '0;
  bit          m_ovf = 1'b0;
  logic [3:0]  e_an  = 4'hF;
  logic [7:0]  e_seg = 8'hFF;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt = 0; m_dig = 0; m_cd = 0; m_shown = 0;
      m_lat = '0; m_ovf = 1'b0;
      e_an = 4'hF; e_seg = 8'hFF;
    end else begin
      e_an = 4'hF;
      e_an[m_dig] = 1'b0;
      e_seg = model_seg(m_dig, cpu_state, seg_data, m_shown, m_ovf);
      m_cnt++;
      if (m_cnt == DIV) begin
        m_cnt = 0;
        m_dig = (m_dig + 1) % 4;
      end
      if (m_cd == 0) begin
        if (gcd != m_lat) begin
          m_lat = gcd;
          m_cd  = 16;
        end
      end else begin
        m_cd--;
        if (m_cd == 0) begin
          if (m_lat > 32'd9999) m_ovf = 1'b1;
          else begin
            m_shown = int'(m_lat);
            m_ovf   = 1'b0;
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (seg_an !== e_an || seg_seg !== e_seg) begin
        failures++;
        $display("FAIL model t=%0t an=%h seg=%h expected an=%h seg=%h",
                 $time, seg_an, seg_seg, e_an, e_seg);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic capture(input string name, input logic [7:0] e3,
                         input logic [7:0] e2, input logic [7:0] e1,
                         input logic [7:0] e0);
    logic [7:0] got [4];
    logic [7:0] exp [4];
    bit         seen [4];
    int         idx;
    exp = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      got[i]  = 8'hxx;
      seen[i] = 1'b0;
    end
    repeat (4 * DIV) begin
      @(negedge clk);
      #1;
      case (seg_an)
        4'hE: idx = 0;
        4'hD: idx = 1;
        4'hB: idx = 2;
        4'h7: idx = 3;
        default: idx = -1;
      endcase
      if (idx >= 0) begin
        got[idx]  = seg_seg;
        seen[idx] = 1'b1;
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (!seen[k] || got[k] !== exp[k]) begin
        failures++;
        $display("FAIL %s digit%0d got=%h expected=%h", name, k, got[k], exp[k]);
      end
    end
  endtask

  logic [3:0] scan_an  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] scan_seg [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};

  initial begin
    rst_n     = 1'b0;
    cpu_state = 1'($urandom_range(0, 1));
    seg_data  = 16'($urandom);
    gcd       = $urandom;
    tick(1);
    chk_en = 1'b1;
    repeat (3) begin
      cpu_state = 1'($urandom_range(0, 1));
      seg_data  = 16'($urandom);
      gcd       = $urandom;
      tick(1);
    end
    @(negedge clk);
    checks++;
    if (seg_an !== 4'hF || seg_seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset an=%h seg=%h expected an=F seg=FF", seg_an, seg_seg);
    end
    tick(1);

    cpu_state = 1'b0;
    seg_data  = 16'h1234;
    gcd       = 32'd0;
    rst_n     = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8 * DIV; i++) begin
      @(negedge clk);
      checks++;
      if (seg_an !== scan_an[(i / DIV) % 4] || seg_seg !== scan_seg[(i / DIV) % 4]) begin
        failures++;
        $display("FAIL scan%0d an=%h seg=%h expected an=%h seg=%h", i, seg_an,
                 seg_seg, scan_an[(i / DIV) % 4], scan_seg[(i / DIV) % 4]);
      end
    end
    tick(1);

    seg_data = 16'hAF90;
    tick(1);
    capture("blank_nibbles", 8'hFF, 8'h7F, 8'h90, 8'hC0);

    cpu_state = 1'b1;
    gcd       = 32'd37;
    tick(20);
    capture("result37", 8'hFF, 8'hFF, 8'hB0, 8'hF8);

    gcd = 32'd9999;
    tick(20);
    capture("result9999", 8'h90, 8'h90, 8'h90, 8'h90);

    gcd = 32'd10000;
    tick(20);
    capture("overflow10000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    gcd = 32'd12;
    tick(7);
    gcd = 32'd18;
    tick(40);
    capture("reconvert18", 8'hFF, 8'hFF, 8'hF9, 8'h80);

    gcd = 32'd50;
    tick(5);
    rst_n = 1'b0;
    gcd   = 32'd6;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    capture("abort_zero", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    tick(10);
    capture("after_abort6", 8'hFF, 8'hFF, 8'hFF, 8'h82);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
